// File: rtl/vga_gen.sv
// Raster timing generator (pixel clock = clk/2) with an RGB565 bouncing-square test pattern.
// Sync, enable and colour are zero-latency decodes of the registered counters; no backpressure.
module vga_gen #(
  parameter int HS_TOTAL = 1343,
  parameter int HS_SYNC  = 135,
  parameter int HS_START = 23,
  parameter int HS_END   = 159,
  parameter int V_TOTAL  = 805,
  parameter int V_SYNC   = 5,
  parameter int V_START  = 2,
  parameter int V_END    = 28,
  parameter int SQUARE_X = 150,
  parameter int SQUARE_Y = 150,
  parameter int SCREEN_X = 480,
  parameter int SCREEN_Y = 272
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vpg_de,
  output logic [15:0] rgb
);

  localparam logic [10:0] H_TOT = 11'(HS_TOTAL);
  localparam logic [10:0] H_SYN = 11'(HS_SYNC);
  localparam logic [10:0] HA0   = 11'(HS_SYNC + HS_END + 2);
  localparam logic [10:0] HA1   = 11'(HS_TOTAL - HS_START - 1);
  localparam logic [9:0]  V_TOT = 10'(V_TOTAL);
  localparam logic [9:0]  V_SYN = 10'(V_SYNC);
  localparam logic [9:0]  VA0   = 10'(V_SYNC + V_END + 2);
  localparam logic [9:0]  VA1   = 10'(V_TOTAL - V_START - 1);
  localparam logic [10:0] SQ_W  = 11'(SQUARE_X);
  localparam logic [10:0] SQ_H  = 11'(SQUARE_Y);
  localparam logic [10:0] SCR_W = 11'(SCREEN_X);
  localparam logic [10:0] SCR_H = 11'(SCREEN_Y);
  localparam logic [9:0]  X_MAX = 10'(SCREEN_X - SQUARE_X);
  localparam logic [9:0]  Y_MAX = 10'(SCREEN_Y - SQUARE_Y);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  sq_x, sq_y;
  logic        dir_x, dir_y;   // 1 = moving towards larger coordinates

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_clk <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      sq_x    <= '0;
      sq_y    <= '0;
      dir_x   <= 1'b1;
      dir_y   <= 1'b1;
    end else begin
      vga_clk <= ~vga_clk;
      if (vga_clk) begin
        if (h_cnt == H_TOT) begin
          h_cnt <= '0;
          if (v_cnt == V_TOT) begin
            v_cnt <= '0;
            // Bounce reverses and steps back within the same frame update.
            if (dir_x) begin
              if (sq_x == X_MAX) begin
                dir_x <= 1'b0;
                sq_x  <= sq_x - 10'd1;
              end else begin
                sq_x  <= sq_x + 10'd1;
              end
            end else begin
              if (sq_x == 10'd0) begin
                dir_x <= 1'b1;
                sq_x  <= sq_x + 10'd1;
              end else begin
                sq_x  <= sq_x - 10'd1;
              end
            end
            if (dir_y) begin
              if (sq_y == Y_MAX) begin
                dir_y <= 1'b0;
                sq_y  <= sq_y - 10'd1;
              end else begin
                sq_y  <= sq_y + 10'd1;
              end
            end else begin
              if (sq_y == 10'd0) begin
                dir_y <= 1'b1;
                sq_y  <= sq_y + 10'd1;
              end else begin
                sq_y  <= sq_y - 10'd1;
              end
            end
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end
    end
  end

  logic [10:0] px, py;
  logic        in_sq, in_scr;

  always_comb begin
    vga_hs = (h_cnt > H_SYN);
    vga_vs = (v_cnt > V_SYN);
    vpg_de = (h_cnt >= HA0) && (h_cnt <= HA1) && (v_cnt >= VA0) && (v_cnt <= VA1);
    px     = h_cnt - HA0;
    py     = {1'b0, v_cnt - VA0};
    in_sq  = ({1'b0, sq_x} <= px) && (px < {1'b0, sq_x} + SQ_W) &&
             ({1'b0, sq_y} <= py) && (py < {1'b0, sq_y} + SQ_H);
    in_scr = (px < SCR_W) && (py < SCR_H);
    rgb    = 16'h0000;
    if (vpg_de) begin
      if (in_sq)       rgb = 16'hFFFF;
      else if (in_scr) rgb = 16'h001F;
    end
  end

endmodule

// File: tb/tb_vga_gen.sv
// Bench for vga_gen on a shrunk raster (40x30 total, 30x23 active, 12x8 window, 4x3 square).
module tb_vga_gen;
  localparam int HS_TOTAL = 39, HS_SYNC = 3, HS_START = 1, HS_END = 3;
  localparam int V_TOTAL = 29, V_SYNC = 1, V_START = 1, V_END = 2;
  localparam int SQUARE_X = 4, SQUARE_Y = 3, SCREEN_X = 12, SCREEN_Y = 8;
  localparam int HT = HS_TOTAL + 1, VT = V_TOTAL + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_clk, vga_hs, vga_vs, vpg_de;
  logic [15:0] rgb;

  int n = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit started = 1'b0;

  vga_gen #(
    .HS_TOTAL(HS_TOTAL), .HS_SYNC(HS_SYNC), .HS_START(HS_START), .HS_END(HS_END),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_START(V_START), .V_END(V_END),
    .SQUARE_X(SQUARE_X), .SQUARE_Y(SQUARE_Y), .SCREEN_X(SCREEN_X), .SCREEN_Y(SCREEN_Y)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vpg_de(vpg_de), .rgb(rgb)
  );

  initial forever #5 clk = ~clk;

  // Clock edges taken out of reset; everything the model needs follows from this.
  always @(posedge clk) n <= rst_n ? n + 1 : 0;

  // Triangle wave: position after f frame updates of a 1-pixel bounce between 0 and lim.
  function automatic int bounce_pos(int f, int lim);
    int p;
    p = f % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  function automatic logic [19:0] model(int edges);
    int p, h, v, f, x, y, px, py;
    logic hs, vs, de;
    logic [15:0] col;
    p  = edges / 2;
    h  = p % HT;
    v  = (p / HT) % VT;
    f  = p / (HT * VT);
    x  = bounce_pos(f, SCREEN_X - SQUARE_X);
    y  = bounce_pos(f, SCREEN_Y - SQUARE_Y);
    hs = (h > HS_SYNC);
    vs = (v > V_SYNC);
    de = (h >= HS_SYNC + HS_END + 2) && (h <= HS_TOTAL - HS_START - 1) &&
         (v >= V_SYNC + V_END + 2) && (v <= V_TOTAL - V_START - 1);
    px = h - (HS_SYNC + HS_END + 2);
    py = v - (V_SYNC + V_END + 2);
    col = 16'h0000;
    if (de) begin
      if (px >= x && px < x + SQUARE_X && py >= y && py < y + SQUARE_Y) col = 16'hFFFF;
      else if (px < SCREEN_X && py < SCREEN_Y) col = 16'h001F;
    end
    return {1'(edges % 2), hs, vs, de, col};
  endfunction

  always @(negedge clk) begin
    if (started) begin
      logic [19:0] exp_v, got_v;
      exp_v = model(n);
      got_v = {vga_clk, vga_hs, vga_vs, vpg_de, rgb};
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL model edge=%0d got clk/hs/vs/de/rgb=%h expected %h", n, got_v, exp_v);
      end
    end
  end

  task automatic check_now(string name, logic e_hs, logic e_vs, logic e_de, logic [15:0] e_rgb);
    n_chk++;
    if ({vga_hs, vga_vs, vpg_de, rgb} !== {e_hs, e_vs, e_de, e_rgb}) begin
      n_fail++;
      $display("FAIL %s got hs=%b vs=%b de=%b rgb=%h expected hs=%b vs=%b de=%b rgb=%h",
               name, vga_hs, vga_vs, vpg_de, rgb, e_hs, e_vs, e_de, e_rgb);
    end
  endtask

  // Waits for pixel (h,v) of frame f, then checks hand-computed outputs there.
  task automatic check_at(int f, int v, int h, logic e_hs, logic e_vs, logic e_de,
                          logic [15:0] e_rgb, string name);
    int target, g;
    target = 2 * (f * HT * VT + v * HT + h);
    g = 0;
    while (n < target && g < 200000) begin
      @(negedge clk);
      g++;
    end
    if (n != target) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s wait reached edge %0d expected edge %0d", name, n, target);
    end else begin
      check_now(name, e_hs, e_vs, e_de, e_rgb);
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    started = 1'b1;
    n_chk++;
    if (vga_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vga_clk got %b expected 0", vga_clk);
    end
    check_now("reset_outputs", 1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;

    check_at(0, 0, 3,   1'b0, 1'b0, 1'b0, 16'h0000, "f0_hsync_last");
    check_at(0, 2, 4,   1'b1, 1'b1, 1'b0, 16'h0000, "f0_after_syncs");
    check_at(0, 5, 7,   1'b1, 1'b1, 1'b0, 16'h0000, "f0_de_before");
    check_at(0, 5, 8,   1'b1, 1'b1, 1'b1, 16'hFFFF, "f0_px0_0");
    check_at(0, 5, 11,  1'b1, 1'b1, 1'b1, 16'hFFFF, "f0_px3_0");
    check_at(0, 5, 12,  1'b1, 1'b1, 1'b1, 16'h001F, "f0_px4_0");
    check_at(0, 5, 20,  1'b1, 1'b1, 1'b1, 16'h0000, "f0_px12_0");
    check_at(0, 7, 11,  1'b1, 1'b1, 1'b1, 16'hFFFF, "f0_px3_2");
    check_at(0, 8, 8,   1'b1, 1'b1, 1'b1, 16'h001F, "f0_px0_3");
    check_at(0, 13, 8,  1'b1, 1'b1, 1'b1, 16'h0000, "f0_px0_8");
    check_at(0, 27, 37, 1'b1, 1'b1, 1'b1, 16'h0000, "f0_last_active");
    check_at(0, 27, 38, 1'b1, 1'b1, 1'b0, 16'h0000, "f0_de_after_h");
    check_at(0, 28, 8,  1'b1, 1'b1, 1'b0, 16'h0000, "f0_de_after_v");
    check_at(1, 5, 8,   1'b1, 1'b1, 1'b1, 16'h001F, "f1_px0_0");
    check_at(1, 6, 9,   1'b1, 1'b1, 1'b1, 16'hFFFF, "f1_px1_1");
    check_at(1, 8, 12,  1'b1, 1'b1, 1'b1, 16'hFFFF, "f1_px4_3");
    check_at(1, 9, 13,  1'b1, 1'b1, 1'b1, 16'h001F, "f1_px5_4");
    check_at(5, 10, 13, 1'b1, 1'b1, 1'b1, 16'hFFFF, "f5_px5_5");
    check_at(5, 13, 16, 1'b1, 1'b1, 1'b1, 16'h0000, "f5_px8_8");
    check_at(6, 11, 14, 1'b1, 1'b1, 1'b1, 16'hFFFF, "f6_px6_6");
    check_at(6, 12, 14, 1'b1, 1'b1, 1'b1, 16'h001F, "f6_px6_7");
    check_at(8, 7, 19,  1'b1, 1'b1, 1'b1, 16'hFFFF, "f8_px11_2");
    check_at(9, 6, 18,  1'b1, 1'b1, 1'b1, 16'hFFFF, "f9_px10_1");
    check_at(9, 6, 19,  1'b1, 1'b1, 1'b1, 16'h001F, "f9_px11_1");

    check_at(10, 10, 15, 1'b1, 1'b1, 1'b1, 16'h001F, "f10_before_reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_now("midreset_outputs", 1'b0, 1'b0, 1'b0, 16'h0000);
    check_at(0, 5, 8, 1'b1, 1'b1, 1'b1, 16'hFFFF, "post_reset_f0_px0_0");
    check_at(1, 5, 8, 1'b1, 1'b1, 1'b1, 16'h001F, "post_reset_f1_px0_0");
    check_at(1, 6, 9, 1'b1, 1'b1, 1'b1, 16'hFFFF, "post_reset_f1_px1_1");

    @(negedge clk);
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_gen.md
Name: vga_gen

Overview:
Self-contained video pattern generator. It divides the system clock by 2 to make a pixel clock and produces HSYNC, VSYNC and data-enable for a 1344x806 total raster with 1024x768 active. It also generates 16-bit RGB565 pixel data: a square that bounces inside a SCREEN_X x SCREEN_Y window at the top-left of the active area. It sits directly in front of the LCD/VGA pins.

Parameters:
HS_TOTAL, 1343, horizontal total minus 1 (pixel clocks per line = 1344)
HS_SYNC, 135, hsync width minus 1 (136)
HS_START, 23, front porch minus 1 (24)
HS_END, 159, back porch minus 1 (160)
V_TOTAL, 805, vertical total minus 1 (806 lines)
V_SYNC, 5, vsync width minus 1 (6 lines)
V_START, 2, vertical front porch minus 1 (3)
V_END, 28, vertical back porch minus 1 (29)
SQUARE_X, 150, square width in pixels
SQUARE_Y, 150, square height in pixels
SCREEN_X, 480, width of the bounce window in pixels
SCREEN_Y, 272, height of the bounce window in pixels

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst_n  in  1  synchronous, active-low reset
vga_clk  out  1  pixel clock = clk/2, registered
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vpg_de  out  1  data enable, high in the active 1024x768 region
rgb  out  16  pixel colour, RGB565 ({R[4:0],G[5:0],B[4:0]})

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - vga_clk=0, h_cnt=0, v_cnt=0, square position (0,0), direction +x/+y.
  - Resulting outputs: vga_hs=0, vga_vs=0, vpg_de=0, rgb=0.
- vga_clk toggles on every clk edge out of reset.
- pix_en = (vga_clk==1). Counters advance only on clk edges with pix_en=1, so they change on vga_clk falling edges and are stable at vga_clk rising edges.
- Horizontal counter: h_cnt 11 bits, 0..HS_TOTAL, then wraps to 0.
- Vertical counter: v_cnt 10 bits, increments when h_cnt wraps, runs 0..V_TOTAL, then wraps to 0.
- vga_hs = 0 when h_cnt <= HS_SYNC, else 1.
- vga_vs = 0 when v_cnt <= V_SYNC, else 1.
- Active horizontal window: HA0 = HS_SYNC+HS_END+2 (296) <= h_cnt <= HS_TOTAL-HS_START-1 (1319).
- Active vertical window: VA0 = V_SYNC+V_END+2 (35) <= v_cnt <= V_TOTAL-V_START-1 (802).
- vpg_de = 1 in both active windows, else 0.
- Pixel coordinates: px = h_cnt-HA0, py = v_cnt-VA0, valid only while vpg_de=1.
- Output decode: hs, vs, de and rgb are combinational decodes of the registered counters and square state, with zero latency relative to the counters.
- rgb priority:
  - vpg_de=0: 16'h0000.
  - Inside square (sq_x <= px < sq_x+SQUARE_X and sq_y <= py < sq_y+SQUARE_Y): 16'hFFFF (white).
  - Otherwise, px<SCREEN_X and py<SCREEN_Y: 16'h001F (blue).
  - Otherwise: 16'h0000.
- Square motion:
  - Updates once per frame, on the pix_en edge where h_cnt==HS_TOTAL and v_cnt==V_TOTAL.
  - Each axis moves 1 pixel in its current direction.
  - X bounce: if moving +x and sq_x==SCREEN_X-SQUARE_X, reverse and step -1 in that same update. If moving -x and sq_x==0, reverse and step +1.
  - Y bounces the same way against SCREEN_Y-SQUARE_Y and 0.
  - The square never leaves the window. Positions are 10-bit unsigned.
- Reset mid-frame: all state returns to reset values at that edge, and a new frame starts from h_cnt=v_cnt=0.

Test Plan:
1. Clock and reset: hold rst_n=0 for 5 clk -> vga_clk=0, vga_hs=0, vga_vs=0, vpg_de=0, rgb=0. After release, vga_clk period = 2 clk (40 ns at 50 MHz).
2. Line timing: measure over lines -> vga_hs period 1344 vga_clk, low for 136. vpg_de rises at h_cnt=296 and stays high for exactly 1024 vga_clk on lines 35..802.
3. Frame timing: vga_vs period 806 lines = 2,166,528 clk, low for 6 lines. Exactly 768 lines per frame carry vpg_de.
4. Frame-0 pattern:
   - pixel (0,0) and (149,149) -> 16'hFFFF
   - pixel (150,0) and (0,150) -> 16'h001F
   - pixel (480,0) and (0,272) -> 16'h0000
   - rgb=0 whenever vpg_de=0
5. Motion: after frame 1 completes, pixel (0,0) is blue and (1,1)..(150,150) is white. After 330 frames sq_x=330. In frame 331 sq_x=329 (x bounce). sq_y peaks at 122 after 122 frames, then decreases.
6. Mid-frame reset: assert rst_n=0 for one clk during an active line -> counters and square return to 0, and the next frame starts with vga_hs and vga_vs low.
